// File: rtl/softmax_normalizer.sv
// Pseudo-softmax normalizer: buffers N samples, sums them, then emits x_k*255/S per sample
// through a bit-serial restoring divider. Define SOFTMAX_ROUND_EN for round-to-nearest quotients.
module softmax_normalizer #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int CW  = $clog2(N);
   localparam int SW  = W + CW;
   localparam int DW  = 2 * W + CW;
   localparam int DCW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DIVIDE  = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    sample_buf [N];
   logic [SW-1:0]   sum;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   idx;
   logic [DCW-1:0]  div_cnt;
   logic [SW-1:0]   rem;
   logic [W-1:0]    quot;

   logic [DW-1:0]   bias;
   logic [DW-1:0]   dividend;
   logic [DCW-1:0]  bit_pos;
   logic [SW:0]     rem_sh;
   logic            rem_ge;
   logic [SW-1:0]   rem_sub;

   // x*255 plus an optional half-divisor bias; the sum stays below 256*S so it fits in DW bits.
   function automatic logic [DW-1:0] make_dividend(input logic [W-1:0] x, input logic [DW-1:0] b);
      logic [DW-1:0] d;
      d = (DW'(x) << 8) - DW'(x);
      return d + b;
   endfunction

   // A zero sum would otherwise yield an all-ones quotient.
   function automatic logic [W-1:0] finish_quot(input logic [W-1:0] q, input logic [SW-1:0] s);
      return (s == '0) ? '0 : q;
   endfunction

`ifdef SOFTMAX_ROUND_EN
   assign bias = DW'(sum >> 1);
`else
   assign bias = '0;
`endif

   assign dividend = make_dividend(sample_buf[idx], bias);
   assign bit_pos  = DCW'(DW - 1) - div_cnt;
   assign rem_sh   = {rem, dividend[bit_pos]};
   assign rem_ge   = (rem_sh >= {1'b0, sum});
   assign rem_sub  = rem_sh[SW-1:0] - sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cnt       <= '0;
         idx       <= '0;
         div_cnt   <= '0;
         rem       <= '0;
         quot      <= '0;
         for (int i = 0; i < N; i++) sample_buf[i] <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_valid && in_ready) begin
                  sample_buf[cnt] <= in_data;
                  sum             <= sum + SW'(in_data);
                  if (cnt == CW'(N - 1)) begin
                     cnt      <= '0;
                     idx      <= '0;
                     div_cnt  <= '0;
                     rem      <= '0;
                     quot     <= '0;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     state    <= DIVIDE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            // DW restoring iterations, then one cycle to publish the quotient.
            DIVIDE: begin
               if (div_cnt == DCW'(DW)) begin
                  out_data  <= finish_quot(quot, sum);
                  out_valid <= 1'b1;
                  out_last  <= (idx == CW'(N - 1));
                  state     <= OUTPUT;
               end else begin
                  rem     <= rem_ge ? rem_sub : rem_sh[SW-1:0];
                  quot    <= {quot[W-2:0], rem_ge};
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (idx == CW'(N - 1)) begin
                     sum      <= '0;
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                     state    <= COLLECT;
                  end else begin
                     idx     <= idx + 1'b1;
                     div_cnt <= '0;
                     rem     <= '0;
                     quot    <= '0;
                     state   <= DIVIDE;
                  end
               end
            end

            default: begin
               state     <= COLLECT;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               cnt       <= '0;
               sum       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed self-checking bench for softmax_normalizer (N=4, W=8, DW=18).
module tb_softmax_normalizer;

   localparam int LAT = 19;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int first_acc, last_acc, hs_cyc, valid_cyc, ref_cyc;

`ifdef SOFTMAX_ROUND_EN
   int uni_exp     = 64;
   int ramp_exp[4] = '{26, 51, 77, 102};
`else
   int uni_exp     = 63;
   int ramp_exp[4] = '{25, 51, 76, 102};
`endif
   int hot_exp[4]  = '{255, 0, 0, 0};

   softmax_normalizer #(.N(4), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic send_vec(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      logic [7:0] v[4];
      int guard;
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = v[i];
         guard    = 0;
         while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) check("accept_wait", 32'(in_ready), 1);
         @(posedge clk);
         #1;
         if (i == 0) first_acc = cyc;
         last_acc = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic recv_one(input int exp_d, input bit exp_l, input bit stall, input string tag);
      int guard;
      logic [7:0] d0;
      logic l0;
      bit stable;
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      valid_cyc = cyc;
      check({tag, "_vld"},  32'(out_valid), 1);
      check({tag, "_data"}, 32'(out_data), exp_d);
      check({tag, "_last"}, 32'(out_last), 32'(exp_l));
      if (stall) begin
         d0 = out_data;
         l0 = out_last;
         stable = 1'b1;
         in_valid = 1'b1;
         in_data  = 8'hAA;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!out_valid || out_data !== d0 || out_last !== l0 || in_ready !== 1'b0 || busy !== 1'b1)
               stable = 1'b0;
         end
         in_valid = 1'b0;
         check({tag, "_hold"}, 32'(stable), 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      hs_cyc = cyc;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data",  32'(out_data), 0);
      check("rst_out_last",  32'(out_last), 0);
      check("rst_busy",      32'(busy), 0);
      rst = 1'b0;

      send_vec(8'd64, 8'd64, 8'd64, 8'd64);
      for (int i = 0; i < 4; i++) recv_one(uni_exp, i == 3, 1'b0, "uni");

      send_vec(8'd10, 8'd20, 8'd30, 8'd40);
      ref_cyc = last_acc;
      for (int i = 0; i < 4; i++) begin
         recv_one(ramp_exp[i], i == 3, 1'b0, "ramp");
         check("ramp_lat", valid_cyc - ref_cyc, LAT);
         ref_cyc = hs_cyc;
      end

      send_vec(8'd255, 8'd0, 8'd0, 8'd0);
      for (int i = 0; i < 4; i++) recv_one(hot_exp[i], i == 3, 1'b0, "hot");

      send_vec(8'd0, 8'd0, 8'd0, 8'd0);
      ref_cyc = last_acc;
      for (int i = 0; i < 4; i++) begin
         recv_one(0, i == 3, 1'b0, "zero");
         check("zero_lat", valid_cyc - ref_cyc, LAT);
         ref_cyc = hs_cyc;
      end

      send_vec(8'd10, 8'd20, 8'd30, 8'd40);
      for (int i = 0; i < 4; i++) recv_one(ramp_exp[i], i == 3, 1'b1, "bp");

      send_vec(8'd10, 8'd20, 8'd30, 8'd40);
      for (int i = 0; i < 2; i++) recv_one(ramp_exp[i], 1'b0, 1'b0, "pre_rst");
      repeat (5) @(negedge clk);
      check("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_in_ready",  32'(in_ready), 1);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_busy",      32'(busy), 0);
      send_vec(8'd10, 8'd20, 8'd30, 8'd40);
      for (int i = 0; i < 4; i++) recv_one(ramp_exp[i], i == 3, 1'b0, "post_rst");

      send_vec(8'd255, 8'd0, 8'd0, 8'd0);
      fork
         begin
            for (int i = 0; i < 4; i++) recv_one(hot_exp[i], i == 3, 1'b0, "b2b_a");
         end
         begin
            send_vec(8'd10, 8'd20, 8'd30, 8'd40);
         end
      join
      check("b2b_first_accept", first_acc - hs_cyc, 1);
      for (int i = 0; i < 4; i++) recv_one(ramp_exp[i], i == 3, 1'b0, "b2b_b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
